// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS memory-side blocks: FSM encoding,
// requester IDs, default bus widths and the arbitration priority rule.
package mips_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;

    localparam logic REQ_IF  = 1'b0;
    localparam logic REQ_MEM = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_IF_BUS  = 3'd1,
        ST_MEM_BUS = 3'd2,
        ST_RESP    = 3'd3,
        ST_ERR     = 3'd4
    } arb_state_e;

    // MEM normally wins a tie; IF wins only when MEM took the previous grant.
    function automatic logic arb_pick_mem(input logic mem_pend,
                                          input logic if_pend,
                                          input logic last_served);
        return mem_pend && (!if_pend || (last_served != REQ_MEM));
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts bus wait cycles without an acknowledge; expired holds once the
// count reaches TIMEOUT until the next clear.
module mem_wait_timer #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] count;

    assign expired = (count == CNT_W'(TIMEOUT));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !expired) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one variable-latency memory bus between instruction fetch and the
// MEM stage, one transaction at a time, and raises the pipeline stalls.
module mem_port_arbiter
    import mips_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic [DATA_W-1:0]   if_rdata,
    output logic                if_valid,
    input  logic                mem_rd,
    input  logic                mem_wr,
    input  logic [ADDR_W-1:0]   mem_addr,
    input  logic [DATA_W-1:0]   mem_wdata,
    input  logic [DATA_W/8-1:0] mem_be,
    output logic [DATA_W-1:0]   mem_rdata,
    output logic                mem_done,
    output logic                bus_req,
    output logic                bus_we,
    output logic [ADDR_W-1:0]   bus_addr,
    output logic [DATA_W-1:0]   bus_wdata,
    output logic [DATA_W/8-1:0] bus_be,
    input  logic                bus_ack,
    input  logic [DATA_W-1:0]   bus_rdata,
    output logic                stall_if,
    output logic                stall_mem,
    output logic                timeout_err
);

    arb_state_e state, state_nxt;
    logic       last_served;
    logic       mem_pend, if_pend, pick_mem, grant;
    logic       in_bus, expired;

    assign mem_pend = mem_rd | mem_wr;
    assign if_pend  = if_req;
    assign pick_mem = arb_pick_mem(mem_pend, if_pend, last_served);
    assign grant    = (state == ST_IDLE) && (mem_pend || if_pend);
    assign in_bus   = (state == ST_IF_BUS) || (state == ST_MEM_BUS);

    // Stalls are forced low while reset is held so every output reads zero.
    assign stall_if  = if_pend & ~if_valid & ~rst;
    assign stall_mem = mem_pend & ~mem_done & ~rst;

    mem_wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_wait_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (grant),
        .enable  (in_bus && !bus_ack),
        .expired (expired)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        bus_req     = 1'b0;
        if_valid    = 1'b0;
        mem_done    = 1'b0;
        timeout_err = 1'b0;
        case (state)
            ST_IDLE: begin
                if (mem_pend || if_pend) begin
                    state_nxt = pick_mem ? ST_MEM_BUS : ST_IF_BUS;
                end
            end
            ST_IF_BUS, ST_MEM_BUS: begin
                bus_req = 1'b1;
                // An ack landing on the expiry cycle still completes normally.
                if (bus_ack) begin
                    state_nxt = ST_RESP;
                end else if (expired) begin
                    state_nxt = ST_ERR;
                end
            end
            ST_RESP: begin
                if_valid  = (last_served == REQ_IF);
                mem_done  = (last_served == REQ_MEM);
                state_nxt = ST_IDLE;
            end
            ST_ERR: begin
                timeout_err = 1'b1;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_served <= REQ_IF;
            bus_addr    <= '0;
            bus_we      <= 1'b0;
            bus_wdata   <= '0;
            bus_be      <= '0;
            if_rdata    <= '0;
            mem_rdata   <= '0;
        end else begin
            if (grant) begin
                last_served <= pick_mem ? REQ_MEM : REQ_IF;
                if (pick_mem) begin
                    bus_addr  <= mem_addr;
                    bus_we    <= mem_wr;
                    bus_wdata <= mem_wr ? mem_wdata : '0;
                    bus_be    <= mem_be;
                end else begin
                    bus_addr  <= if_addr;
                    bus_we    <= 1'b0;
                    bus_wdata <= '0;
                    bus_be    <= '1;
                end
            end
            if (bus_ack && (state == ST_IF_BUS)) begin
                if_rdata <= bus_rdata;
            end
            if (bus_ack && (state == ST_MEM_BUS) && !bus_we) begin
                mem_rdata <= bus_rdata;
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: random requesters and bus latency
// against a transaction-level model, plus directed timeout and reset cases.
module tb_mem_port_arbiter;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_valid;
    logic        mem_rd, mem_wr;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic [31:0] mem_rdata;
    logic        mem_done;
    logic        bus_req, bus_we;
    logic [31:0] bus_addr, bus_wdata;
    logic [3:0]  bus_be;
    logic        bus_ack;
    logic [31:0] bus_rdata;
    logic        stall_if, stall_mem, timeout_err;

    mem_port_arbiter #(
        .ADDR_W  (32),
        .DATA_W  (32),
        .TIMEOUT (TO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .if_req      (if_req),
        .if_addr     (if_addr),
        .if_rdata    (if_rdata),
        .if_valid    (if_valid),
        .mem_rd      (mem_rd),
        .mem_wr      (mem_wr),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_be      (mem_be),
        .mem_rdata   (mem_rdata),
        .mem_done    (mem_done),
        .bus_req     (bus_req),
        .bus_we      (bus_we),
        .bus_addr    (bus_addr),
        .bus_wdata   (bus_wdata),
        .bus_be      (bus_be),
        .bus_ack     (bus_ack),
        .bus_rdata   (bus_rdata),
        .stall_if    (stall_if),
        .stall_mem   (stall_mem),
        .timeout_err (timeout_err)
    );

    initial forever #5 clk = ~clk;

    typedef struct {
        bit          is_mem;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] rdata;
        int          start;
        int          k;
    } bus_t;

    typedef struct {
        bit          is_mem;
        logic [31:0] rdata;
        int          cyc;
    } resp_t;

    bus_t        bus_q[$];
    resp_t       resp_q[$];
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    bit          random_mode = 1'b0;
    bit          drive_en = 1'b0;
    int          free_cyc = 0;
    bit          model_last_mem = 1'b0;
    logic [31:0] model_if_rd = '0;
    logic [31:0] model_mem_rd = '0;
    int          txn_n = 0;
    int          delay_tab[6] = '{2, 1, TO + 1, 1, 3, TO + 1};

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic wait_bus(output bit got);
        got = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bus_req === 1'b1) begin
                got = 1'b1;
                break;
            end
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Reference model: whenever the arbiter is free, grant by the alternation rule.
    initial begin : model
        bit    mp, ip, take_mem;
        int    k;
        bus_t  b;
        resp_t r;
        forever begin
            @(negedge clk);
            if (random_mode && cyc == free_cyc) begin
                mp = mem_rd | mem_wr;
                ip = if_req;
                if (mp || ip) begin
                    take_mem = (mp && ip) ? !model_last_mem : mp;
                    k = (txn_n < 6) ? delay_tab[txn_n] : $urandom_range(1, TO + 1);
                    txn_n++;
                    b.is_mem = take_mem;
                    b.we     = take_mem && mem_wr;
                    b.addr   = take_mem ? mem_addr : if_addr;
                    b.wdata  = mem_wdata;
                    b.be     = mem_be;
                    b.rdata  = $urandom;
                    b.start  = cyc + 1;
                    b.k      = k;
                    r.is_mem = take_mem;
                    if (!take_mem) begin
                        model_if_rd = b.rdata;
                    end else if (!b.we) begin
                        model_mem_rd = b.rdata;
                    end
                    r.rdata = take_mem ? model_mem_rd : model_if_rd;
                    r.cyc   = cyc + k + 1;
                    bus_q.push_back(b);
                    resp_q.push_back(r);
                    model_last_mem = take_mem;
                    free_cyc = cyc + k + 2;
                end else begin
                    free_cyc = cyc + 1;
                end
            end
        end
    end

    // Bus side: checks the command window and plays the slave, with stray acks when idle.
    initial begin : bus_mon
        bit   exp_req;
        bus_t b;
        forever begin
            @(negedge clk);
            if (random_mode) begin
                exp_req = (bus_q.size() > 0) && (cyc >= bus_q[0].start);
                check("bus_req", bus_req, exp_req);
                if (exp_req) begin
                    b = bus_q[0];
                    check("bus_addr", bus_addr, b.addr);
                    check("bus_we", bus_we, b.we);
                    if (b.is_mem) check("bus_be", bus_be, b.be);
                    if (b.we) check("bus_wdata", bus_wdata, b.wdata);
                    if (cyc == b.start + b.k - 1) begin
                        bus_ack   = 1'b1;
                        bus_rdata = b.rdata;
                        void'(bus_q.pop_front());
                    end else begin
                        bus_ack   = 1'b0;
                        bus_rdata = $urandom;
                    end
                end else begin
                    bus_ack   = ($urandom_range(0, 3) == 0);
                    bus_rdata = $urandom;
                end
            end
        end
    end

    // Requester side: completion pulses, returned data and stalls.
    initial begin : resp_mon
        bit exp_if, exp_mem;
        forever begin
            @(negedge clk);
            if (random_mode) begin
                exp_if  = (resp_q.size() > 0) && (resp_q[0].cyc == cyc) && !resp_q[0].is_mem;
                exp_mem = (resp_q.size() > 0) && (resp_q[0].cyc == cyc) && resp_q[0].is_mem;
                check("if_valid", if_valid, exp_if);
                check("mem_done", mem_done, exp_mem);
                check("stall_if", stall_if, if_req & ~exp_if);
                check("stall_mem", stall_mem, (mem_rd | mem_wr) & ~exp_mem);
                check("timeout_err_idle", timeout_err, 1'b0);
                if (exp_if) check("if_rdata", if_rdata, resp_q[0].rdata);
                if (exp_mem) check("mem_rdata", mem_rdata, resp_q[0].rdata);
                if (exp_if || exp_mem) void'(resp_q.pop_front());
            end
        end
    end

    initial begin : if_drv
        int gap;
        bit seen;
        gap = 0;
        forever begin
            @(negedge clk);
            seen = if_valid;
            @(posedge clk);
            #1;
            if (!random_mode) continue;
            if (if_req) begin
                if (seen) begin
                    if_req = 1'b0;
                    gap = $urandom_range(0, 3);
                    if (gap == 0 && drive_en) begin
                        if_req  = 1'b1;
                        if_addr = $urandom & 32'hFFFF_FFFC;
                    end
                end
            end else if (drive_en) begin
                if (gap > 0) begin
                    gap--;
                end else begin
                    if_req  = 1'b1;
                    if_addr = $urandom & 32'hFFFF_FFFC;
                end
            end
        end
    end

    initial begin : mem_drv
        int gap, op;
        bit seen;
        gap = 0;
        forever begin
            @(negedge clk);
            seen = mem_done;
            @(posedge clk);
            #1;
            if (!random_mode) continue;
            if (mem_rd | mem_wr) begin
                if (seen) begin
                    mem_rd = 1'b0;
                    mem_wr = 1'b0;
                    gap = $urandom_range(0, 3);
                end
            end
            if (!(mem_rd | mem_wr) && drive_en && !seen) begin
                if (gap > 0) begin
                    gap--;
                end else begin
                    op        = $urandom_range(0, 2);
                    mem_rd    = (op != 1);
                    mem_wr    = (op != 0);
                    mem_addr  = $urandom & 32'hFFFF_FFFC;
                    mem_wdata = $urandom;
                    mem_be    = 4'($urandom_range(1, 15));
                end
            end else if (!(mem_rd | mem_wr) && drive_en && seen && gap == 0) begin
                op        = $urandom_range(0, 2);
                mem_rd    = (op != 1);
                mem_wr    = (op != 0);
                mem_addr  = $urandom & 32'hFFFF_FFFC;
                mem_wdata = $urandom;
                mem_be    = 4'($urandom_range(1, 15));
            end
        end
    end

    initial begin : watchdog
        repeat (20000) @(posedge clk);
        errors++;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : main
        bit got, drained;

        rst = 1'b1;
        if_req = 1'b1; if_addr = 32'h40;
        mem_rd = 1'b1; mem_wr = 1'b0;
        mem_addr = '0; mem_wdata = '0; mem_be = '0;
        bus_ack = 1'b1; bus_rdata = 32'hFFFF_FFFF;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_bus_req", bus_req, 0);
        check("rst_bus_we", bus_we, 0);
        check("rst_bus_addr", bus_addr, 0);
        check("rst_bus_wdata", bus_wdata, 0);
        check("rst_bus_be", bus_be, 0);
        check("rst_if_rdata", if_rdata, 0);
        check("rst_mem_rdata", mem_rdata, 0);
        check("rst_if_valid", if_valid, 0);
        check("rst_mem_done", mem_done, 0);
        check("rst_stall_if", stall_if, 0);
        check("rst_stall_mem", stall_mem, 0);
        check("rst_timeout_err", timeout_err, 0);

        @(posedge clk);
        #1;
        if_req = 1'b0; mem_rd = 1'b0; bus_ack = 1'b0; rst = 1'b0;
        @(negedge clk);
        free_cyc = cyc + 1;
        random_mode = 1'b1;
        drive_en = 1'b1;
        repeat (500) @(posedge clk);
        @(negedge clk);
        drive_en = 1'b0;
        drained = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (bus_q.size() == 0 && resp_q.size() == 0 && !if_req && !mem_rd && !mem_wr) begin
                drained = 1'b1;
                break;
            end
        end
        check("drain", drained, 1);
        random_mode = 1'b0;
        bus_ack = 1'b0;

        // Hung bus: a held read with no ack must end in the sticky error state.
        @(posedge clk);
        #1;
        mem_rd = 1'b1; mem_wr = 1'b0; mem_addr = 32'h200; mem_be = 4'hF;
        wait_bus(got);
        check("to_grant", got, 1);
        for (int i = 1; i <= TO; i++) begin
            @(negedge clk);
            check("to_bus_req_hold", bus_req, 1);
            check("to_err_early", timeout_err, 0);
        end
        @(negedge clk);
        check("to_err", timeout_err, 1);
        check("to_bus_req_drop", bus_req, 0);
        check("to_stall_mem", stall_mem, 1);
        bus_ack = 1'b1;
        bus_rdata = 32'hBAD0_BAD0;
        @(negedge clk);
        bus_ack = 1'b0;
        check("to_late_ack_err", timeout_err, 1);
        check("to_late_ack_done", mem_done, 0);
        check("to_late_ack_rdata", mem_rdata, model_mem_rd);
        @(negedge clk);
        check("to_sticky", timeout_err, 1);
        check("to_no_bus", bus_req, 0);

        rst = 1'b1;
        #1;
        check("rst_err_clear", timeout_err, 0);
        check("rst_err_stall", stall_mem, 0);
        @(posedge clk);
        #1;
        if_req = 1'b1; if_addr = 32'h44; mem_addr = 32'h300; rst = 1'b0;
        wait_bus(got);
        check("post_err_grant", got, 1);
        check("post_err_mem_first", bus_addr, 32'h300);

        // Reset mid MEM_BUS, then both still pending: MEM must win again.
        rst = 1'b1;
        #1;
        check("mid_rst_bus_req", bus_req, 0);
        check("mid_rst_stall_mem", stall_mem, 0);
        check("mid_rst_stall_if", stall_if, 0);
        check("mid_rst_bus_addr", bus_addr, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        wait_bus(got);
        check("mid_rst_grant", got, 1);
        check("mid_rst_mem_first", bus_addr, 32'h300);
        check("mid_rst_we", bus_we, 0);
        bus_ack = 1'b1; bus_rdata = 32'h1234_5678;
        @(negedge clk);
        bus_ack = 1'b0;
        check("mid_mem_done", mem_done, 1);
        check("mid_mem_rdata", mem_rdata, 32'h1234_5678);
        check("mid_if_valid_low", if_valid, 0);
        check("mid_stall_if", stall_if, 1);
        @(posedge clk);
        #1;
        mem_rd = 1'b0;
        wait_bus(got);
        check("if_grant", got, 1);
        check("if_bus_addr", bus_addr, 32'h44);
        check("if_bus_we", bus_we, 0);
        @(negedge clk);
        check("if_wait_bus_req", bus_req, 1);
        bus_ack = 1'b1; bus_rdata = 32'h2108_0001;
        @(negedge clk);
        bus_ack = 1'b0;
        check("if_valid_pulse", if_valid, 1);
        check("if_rdata_val", if_rdata, 32'h2108_0001);
        check("if_stall_released", stall_if, 0);
        @(posedge clk);
        #1;
        if_req = 1'b0;
        @(negedge clk);
        check("if_valid_single", if_valid, 0);
        check("if_rdata_hold", if_rdata, 32'h2108_0001);
        check("mem_rdata_hold", mem_rdata, 32'h1234_5678);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
